seg7_readback_decoder: RTL and testbench
========================================

Name: seg7_readback_decoder

Overview:
Inverse of the team's hex-to-seven-segment path: monitors the multiplexed, active-low segment and anode lines driving the board display and recovers the displayed hex value. It runs in the display clock domain alongside the display driver. Its outputs feed self-check logic and the UART debug path so that the shown value can be compared against the intended value. Captures are filtered by a stability counter, and segment patterns outside the 16 legal glyphs are flagged.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode lines); must be at least 1.
STABLE_CYCLES, 4, number of consecutive identical samples (anode + segments) required before a capture; must be at least 2.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
seg_in  in  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
an_in  in  NUM_DIGITS  digit anodes, active-low; bit i selects digit i, with digit 0 as the least significant nibble.
clear_err  in  1  clears pattern_err, sampled every cycle.
value_out  out  4*NUM_DIGITS  recovered value; nibble i is bits [4i+3:4i].
digit_valid  out  NUM_DIGITS  bit i is set when nibble i holds a legal decoded glyph.
frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse.
pattern_err  out  NUM_DIGITS  sticky per-digit flag for an illegal glyph.

Behaviour:
- Reset: the synchronous rst=1 clears value_out, digit_valid, frame_valid, pattern_err, the captured mask, the stability counter, the captured-this-dwell flag and the input sample registers to 0. This applies mid-capture with no partial update.
- Input stage: seg_in and an_in are registered once and inverted to active-high (seg_h, an_h). All further logic uses these registered values.
- Anode qualification: a sample is qualified only when exactly one bit of an_h is 1. If zero or several bits are 1, the counter returns to 0, the captured-this-dwell flag clears, and no capture occurs.
- Stability counter:
  - A qualified sample equal to the previous registered sample (same an_h and seg_h) increments the counter, saturating at STABLE_CYCLES.
  - A qualified sample that differs sets the counter to 1 and clears the captured-this-dwell flag.
- Capture timing: capture happens once per dwell, on the edge after the counter reaches STABLE_CYCLES with the captured-this-dwell flag clear; the flag is then set. If the inputs are held from before edge E0, the outputs update at edge E0+STABLE_CYCLES+1, i.e. STABLE_CYCLES+1 cycles of latency.
- Decode table (seg_h -> nibble):
  7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7,
  7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
- Legal capture of digit i: write nibble i, set digit_valid[i], set captured-mask bit i.
- Illegal pattern on digit i (any other seg_h, including 00):
  - nibble i is unchanged;
  - digit_valid[i] is cleared;
  - pattern_err[i] is set;
  - captured-mask bit i is set.
- Frame:
  - When the captured mask becomes all ones, frame_valid pulses high for exactly one cycle, on the cycle after the completing capture's output update, and the mask clears.
  - Recapturing the same digit before the frame completes overwrites it and does not pulse.
- clear_err=1 zeroes pattern_err. If a new error on digit i coincides with clear_err, pattern_err[i] ends at 1 (set wins); other bits clear.
- A blank or ghost interval between digits (all anodes off) only resets stability and never corrupts stored nibbles.

Test Plan:
- Reset then idle with an_in=all 1s -> value_out=0000, digit_valid=0, frame_valid never pulses, pattern_err=0.
- Scan digits 0..3 with active-low patterns ~7'h4F, ~7'h3D, ~7'h4E, ~7'h1F (E, D, C, B), 8 cycles each -> value_out=16'hBCDE, digit_valid=4'hF, one frame_valid pulse 1 cycle after the digit-3 update.
- Digit 0 showing ~7'h30 for only STABLE_CYCLES-1=3 cycles, then anodes off -> no capture; for exactly 4 cycles -> nibble0=1 updated at E0+5.
- Digit 2 held at ~7'h00 (all segments lit is 7F=8, so use seg_h=00 i.e. seg_in=7'h7F) -> pattern_err[2]=1, digit_valid[2]=0, nibble2 unchanged; pulse clear_err on the same cycle as that capture -> pattern_err[2] stays 1, and a later clear_err clears it.
- an_in=4'b1100 (two digits active) with stable segments for 20 cycles -> no capture, counter held at 0; then a valid single-anode dwell is captured normally.
- Assert rst mid-dwell at counter=2, then release and continue the same dwell -> all outputs are 0 after the reset edge, and the capture occurs STABLE_CYCLES+1 cycles after release.

Source files
------------

// File: rtl/seg7_readback_decoder.sv
// Recovers the hex value shown on a multiplexed, active-low seven-segment
// display by sampling its segment and anode lines.
module seg7_readback_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic [NUM_DIGITS-1:0]   pattern_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = '1;

    logic [6:0]              seg_h;
    logic [6:0]              prev_seg;
    logic [NUM_DIGITS-1:0]   an_h;
    logic [NUM_DIGITS-1:0]   prev_an;
    logic [CW-1:0]           cnt;
    logic                    done;
    logic [NUM_DIGITS-1:0]   mask;

    logic                    qualified;
    logic                    same;
    logic                    capture;
    logic                    legal;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic [CW-1:0]           cnt_n;
    logic                    done_n;
    logic [NUM_DIGITS-1:0]   mask_n;
    logic [4*NUM_DIGITS-1:0] value_n;
    logic [NUM_DIGITS-1:0]   valid_n;
    logic [NUM_DIGITS-1:0]   err_n;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h7B:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h4F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    // prev_* always holds the last sample the counter accounted for,
    // so it is the glyph to capture once the dwell is stable.
    always_comb begin
        qualified = (an_h != '0) &&
                    ((an_h & (an_h - NUM_DIGITS'(1))) == '0);
        same      = (an_h == prev_an) && (seg_h == prev_seg);
        capture   = (cnt == CNT_MAX) && !done;
        {legal, nib} = decode(prev_seg);
        cap_mask  = capture ? prev_an : '0;

        cnt_n  = '0;
        done_n = 1'b0;
        if (qualified && !same) begin
            cnt_n = CW'(1);
        end else if (qualified) begin
            cnt_n  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            done_n = done | capture;
        end

        value_n = value_out;
        valid_n = digit_valid;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                valid_n[i] = legal;
                if (legal) value_n[4*i +: 4] = nib;
            end
        end

        err_n  = (clear_err ? '0 : pattern_err) | (legal ? '0 : cap_mask);
        mask_n = ((mask == ALL_DIGITS) ? '0 : mask) | cap_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_h       <= '0;
            an_h        <= '0;
            prev_seg    <= '0;
            prev_an     <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            mask        <= '0;
            value_out   <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            pattern_err <= '0;
        end else begin
            seg_h       <= ~seg_in;
            an_h        <= ~an_in;
            prev_seg    <= seg_h;
            prev_an     <= an_h;
            cnt         <= cnt_n;
            done        <= done_n;
            mask        <= mask_n;
            value_out   <= value_n;
            digit_valid <= valid_n;
            frame_valid <= (mask == ALL_DIGITS);
            pattern_err <= err_n;
        end
    end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Bench for seg7_readback_decoder: directed scenarios plus random dwells,
// compared every cycle against a run-length based reference model.
module tb_seg7_readback_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic          clear_err;
    logic [4*ND-1:0] value_out;
    logic [ND-1:0] digit_valid;
    logic          frame_valid;
    logic [ND-1:0] pattern_err;

    seg7_readback_decoder #(
        .NUM_DIGITS(ND),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .an_in(an_in),
        .clear_err(clear_err),
        .value_out(value_out),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                               7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                               7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference state: per-edge sample history and run lengths.
    int q_an[$];
    int q_seg[$];
    int q_run[$];
    bit q_rst[$];
    logic [4*ND-1:0] m_val   = '0;
    logic [ND-1:0]   m_dv    = '0;
    logic [ND-1:0]   m_err   = '0;
    logic [ND-1:0]   m_mask  = '0;
    logic            m_frame = 1'b0;

    function automatic int lookup(input int s);
        for (int i = 0; i < 16; i++)
            if (int'(glyph[i]) == s) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] a,
                              input logic c, input logic r);
        int t, ah, sh, run, d, nib;
        logic [ND-1:0] a_h;
        logic [6:0] s_h;
        logic [3:0] n4;
        t = q_an.size();
        if (r) begin
            q_an.push_back(0);
            q_seg.push_back(0);
            q_run.push_back(0);
            q_rst.push_back(1'b1);
            m_val = '0; m_dv = '0; m_err = '0; m_mask = '0; m_frame = 1'b0;
            return;
        end
        a_h = ~a;
        s_h = ~s;
        ah  = int'(a_h);
        sh  = int'(s_h);
        run = 0;
        if ($countones(a_h) == 1)
            run = (t > 0 && q_an[t-1] == ah && q_seg[t-1] == sh)
                  ? q_run[t-1] + 1 : 1;
        q_an.push_back(ah);
        q_seg.push_back(sh);
        q_run.push_back(run);
        q_rst.push_back(1'b0);

        m_frame = (m_mask == '1);
        if (m_frame) m_mask = '0;
        if (c) m_err = '0;
        // A dwell is captured two edges after its run first reaches SC.
        if (t >= 2 && q_run[t-2] == SC && !q_rst[t-1]) begin
            d = 0;
            for (int i = 0; i < ND; i++)
                if (q_an[t-2] == (1 << i)) d = i;
            nib = lookup(q_seg[t-2]);
            m_mask[d] = 1'b1;
            if (nib >= 0) begin
                n4 = nib[3:0];
                m_val[4*d +: 4] = n4;
                m_dv[d] = 1'b1;
            end else begin
                m_dv[d]  = 1'b0;
                m_err[d] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic [6:0] s, input logic [ND-1:0] a,
                        input logic c, input logic r);
        seg_in = s; an_in = a; clear_err = c; rst = r;
        @(posedge clk);
        model_edge(s, a, c, r);
        @(negedge clk);
        check("value_out", 32'(value_out), 32'(m_val));
        check("digit_valid", 32'(digit_valid), 32'(m_dv));
        check("frame_valid", 32'(frame_valid), 32'(m_frame));
        check("pattern_err", 32'(pattern_err), 32'(m_err));
    endtask

    function automatic logic [ND-1:0] an_of(input int d);
        logic [ND-1:0] one;
        one = ND'(1);
        return ~(one << d);
    endfunction

    task automatic dwell(input int d, input logic [6:0] gh, input int n,
                         input int clr_at);
        for (int i = 0; i < n; i++)
            tick(~gh, an_of(d), (i == clr_at), 1'b0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            tick(7'h7F, '1, 1'b0, 1'b0);
    endtask

    int frames;
    logic [6:0] g;
    logic [ND-1:0] a;
    int len;

    initial begin
        seg_in = 7'h7F; an_in = '1; clear_err = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(7'h7F, '1, 1'b0, 1'b1);
        frames = 0;
        for (int i = 0; i < 10; i++) begin
            tick(7'h7F, '1, 1'b0, 1'b0);
            frames += int'(frame_valid);
        end
        check("idle_value", 32'(value_out), 32'h0);
        check("idle_frames", 32'(frames), 32'h0);

        frames = 0;
        dwell(0, 7'h4F, 8, -1);
        dwell(1, 7'h3D, 8, -1);
        dwell(2, 7'h4E, 8, -1);
        for (int i = 0; i < 8; i++) begin
            tick(~7'h1F, an_of(3), 1'b0, 1'b0);
            frames += int'(frame_valid);
            if (i == 5) check("scan_value", 32'(value_out), 32'hBCDE);
            if (i == 6) check("scan_frame", 32'(frame_valid), 32'h1);
        end
        blank(2);
        check("scan_frames", 32'(frames), 32'h1);
        check("scan_valid", 32'(digit_valid), 32'hF);

        dwell(0, 7'h30, SC - 1, -1);
        blank(5);
        check("short_dwell", 32'(value_out[3:0]), 32'hE);
        dwell(0, 7'h30, SC, -1);
        blank(1);
        check("exact_early", 32'(value_out[3:0]), 32'hE);
        blank(1);
        check("exact_cap", 32'(value_out[3:0]), 32'h1);

        dwell(1, 7'h01, 8, -1);
        blank(2);
        check("err1_set", 32'(pattern_err), 32'h2);
        dwell(2, 7'h00, 8, SC + 1);
        blank(2);
        check("err_set_wins", 32'(pattern_err), 32'h4);
        check("err_keep_val", 32'(value_out), 32'hBCD1);
        check("err_dv", 32'(digit_valid), 32'h9);
        tick(7'h7F, '1, 1'b1, 1'b0);
        check("err_clear", 32'(pattern_err), 32'h0);

        for (int i = 0; i < 20; i++) tick(~7'h33, 4'b1100, 1'b0, 1'b0);
        check("multi_an", 32'(value_out), 32'hBCD1);
        dwell(3, 7'h33, 8, -1);
        blank(2);
        check("after_multi", 32'(value_out), 32'h4CD1);

        dwell(1, 7'h5B, 3, -1);
        tick(~7'h5B, an_of(1), 1'b0, 1'b1);
        check("rst_value", 32'(value_out), 32'h0);
        check("rst_dv", 32'(digit_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(~7'h5B, an_of(1), 1'b0, 1'b0);
            if (i == SC) check("rst_early", 32'(value_out), 32'h0);
            if (i == SC + 1) check("rst_cap", 32'(value_out), 32'h0050);
        end
        blank(2);

        for (int k = 0; k < 300; k++) begin
            g = ($urandom_range(7) == 0) ? 7'($urandom)
                                         : glyph[$urandom_range(15)];
            a = ($urandom_range(99) < 85) ? an_of($urandom_range(ND - 1))
                                          : ND'($urandom);
            len = $urandom_range(10, 1);
            for (int i = 0; i < len; i++)
                tick(~g, a, ($urandom_range(9) == 0),
                     ($urandom_range(199) == 0));
            if ($urandom_range(1) == 0) blank($urandom_range(2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
